// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a per-register pending-write scoreboard.
// Decode reads and reserves destinations; writeback writes and releases them.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS),
    parameter int NRP   = 2,
    parameter int CNTW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RegWriteW,
    input  logic [AW-1:0]       RdW,
    input  logic [XLEN-1:0]     ResultW,
    input  logic [NRP*AW-1:0]   RAddrD,
    output logic [NRP*XLEN-1:0] RDataD,
    input  logic [NRP-1:0]      RdEnD,
    input  logic                ReserveD,
    input  logic [AW-1:0]       RdD,
    output logic                ReserveReady,
    input  logic                Flush,
    output logic [NRP-1:0]      HazardD,
    output logic                StallD
);

    localparam logic [CNTW-1:0] CMAX = '1;

    logic [XLEN-1:0] rf_q  [NREGS];
    logic [CNTW-1:0] cnt_q [NREGS];
    logic [CNTW-1:0] cnt_d [NREGS];
    logic            reserve_ev;
    logic            release_ev;

    assign reserve_ev   = ReserveD && (RdD != '0) && (cnt_q[RdD] != CMAX);
    assign release_ev   = RegWriteW && (RdW != '0) && (cnt_q[RdW] != '0);
    assign ReserveReady = (RdD == '0) || (cnt_q[RdD] != CMAX);

    // A reserve and a release on the same register cancel out.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (Flush) begin
                cnt_d[r] = '0;
            end else if (reserve_ev && (RdD == AW'(r)) && !(release_ev && (RdW == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (release_ev && (RdW == AW'(r)) && !(reserve_ev && (RdD == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
        end else if (RegWriteW && (RdW != '0)) begin
            rf_q[RdW] <= ResultW;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_port
        logic [AW-1:0] addr;
        logic          byp;

        assign addr = RAddrD[i*AW +: AW];
        // Bypass is suppressed in reset so reads stay zero while the array is held clear.
        assign byp  = rst_n && RegWriteW && (RdW == addr);
        assign RDataD[i*XLEN +: XLEN] = (addr == '0) ? '0 : (byp ? ResultW : rf_q[addr]);
        assign HazardD[i] = RdEnD[i] && (addr != '0) && (cnt_q[addr] != '0) &&
                            !(release_ev && (RdW == addr) && (cnt_q[addr] == CNTW'(1)));
    end

    assign StallD = |HazardD;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, scoreboard counting, simultaneous events and flush.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int CNTW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                RegWriteW;
    logic [AW-1:0]       RdW;
    logic [XLEN-1:0]     ResultW;
    logic [NRP*AW-1:0]   RAddrD;
    logic [NRP*XLEN-1:0] RDataD;
    logic [NRP-1:0]      RdEnD;
    logic                ReserveD;
    logic [AW-1:0]       RdD;
    logic                ReserveReady;
    logic                Flush;
    logic [NRP-1:0]      HazardD;
    logic                StallD;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RAddrD(RAddrD), .RDataD(RDataD), .RdEnD(RdEnD), .ReserveD(ReserveD), .RdD(RdD),
        .ReserveReady(ReserveReady), .Flush(Flush), .HazardD(HazardD), .StallD(StallD)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        ReserveD  = 1'b0; RdD = '0; Flush = 1'b0;
        RAddrD    = '0;   RdEnD = '0;
    endtask

    task automatic wr(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        RegWriteW = 1'b1; RdW = r; ResultW = d;
    endtask

    task automatic rsv(input logic [AW-1:0] r);
        ReserveD = 1'b1; RdD = r;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [NRP-1:0] en);
        RAddrD = {a1, a0}; RdEnD = en;
    endtask

    function automatic logic [XLEN-1:0] rdata(input int p);
        return RDataD[p*XLEN +: XLEN];
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset mid-operation
        wr(5, 32'hDEADBEEF); step(); idle();
        rsv(5); step(); idle();
        rd(5, 5, 2'b01); settle();
        check_eq("pre_reset_data", rdata(0), 32'hDEADBEEF);
        check_eq("pre_reset_hazard", 32'(HazardD), 32'h1);
        rst_n = 1'b0;
        wr(5, 32'h11112222); rsv(5); #1;
        check_eq("rst_rdata0", rdata(0), 32'h0);
        check_eq("rst_rdata1", rdata(1), 32'h0);
        check_eq("rst_hazard", 32'(HazardD), 32'h0);
        check_eq("rst_stall", 32'(StallD), 32'h0);
        check_eq("rst_ready", 32'(ReserveReady), 32'h1);
        step(); settle();
        check_eq("rst_after_edge_rdata", rdata(0), 32'h0);
        rst_n = 1'b1; idle(); rd(5, 5, 2'b11); #1;
        check_eq("post_rst_rdata", rdata(1), 32'h0);
        check_eq("post_rst_hazard", 32'(HazardD), 32'h0);
        step();

        // Write and bypass
        idle(); wr(7, 32'h12345678); rd(7, 7, 2'b00); settle();
        check_eq("bypass_p0", rdata(0), 32'h12345678);
        check_eq("bypass_p1", rdata(1), 32'h12345678);
        step(); idle(); rd(7, 3, 2'b00); settle();
        check_eq("stored_x7", rdata(0), 32'h12345678);
        check_eq("unwritten_x3", rdata(1), 32'h0);
        wr(0, 32'hFFFFFFFF); rd(0, 0, 2'b11); settle();
        check_eq("x0_bypass_zero", rdata(0), 32'h0);
        step(); idle(); rd(0, 7, 2'b11); settle();
        check_eq("x0_stored_zero", rdata(0), 32'h0);
        check_eq("x0_no_hazard", 32'(HazardD), 32'h0);

        // Scoreboard RAW on x3
        idle(); rsv(3); settle();
        rd(3, 3, 2'b01); settle();
        check_eq("self_no_hazard", 32'(HazardD), 32'h0);
        step(); idle(); rd(3, 3, 2'b01); settle();
        check_eq("raw_hazard", 32'(HazardD), 32'h1);
        check_eq("raw_stall", 32'(StallD), 32'h1);
        wr(3, 32'h000000A5); settle();
        check_eq("raw_landing_hazard", 32'(HazardD), 32'h0);
        check_eq("raw_landing_data", rdata(0), 32'h000000A5);
        step(); idle(); rd(3, 3, 2'b11); settle();
        check_eq("raw_cleared", 32'(HazardD), 32'h0);
        check_eq("raw_stored", rdata(1), 32'h000000A5);

        // WAW counting on x9, CNTW=2 saturates at 3
        idle();
        for (int k = 0; k < 3; k++) begin
            rsv(9); settle();
            check_eq("ready_below_max", 32'(ReserveReady), 32'h1);
            step();
        end
        idle(); RdD = 9; settle();
        check_eq("ready_at_max", 32'(ReserveReady), 32'h0);
        rsv(9); step(); idle();
        rd(9, 0, 2'b01); wr(9, 32'h9); settle();
        check_eq("waw_w1_hazard", 32'(HazardD), 32'h1);
        step(); idle(); rd(9, 0, 2'b01); RdD = 9; settle();
        check_eq("waw_cnt2_hazard", 32'(HazardD), 32'h1);
        check_eq("waw_cnt2_ready", 32'(ReserveReady), 32'h1);
        wr(9, 32'h99); step(); idle();
        rd(9, 0, 2'b01); settle();
        check_eq("waw_cnt1_hazard", 32'(HazardD), 32'h1);
        wr(9, 32'h999); settle();
        check_eq("waw_last_landing", 32'(HazardD), 32'h0);
        step(); idle(); rd(9, 0, 2'b01); settle();
        check_eq("waw_cleared", 32'(HazardD), 32'h0);
        check_eq("waw_data", rdata(0), 32'h999);

        // Simultaneous reserve and release on x4
        idle(); rsv(4); step();
        idle(); rsv(4); wr(4, 32'h44); step();
        idle(); rd(4, 0, 2'b01); settle();
        check_eq("sim_cnt_held", 32'(HazardD), 32'h1);
        wr(4, 32'h45); step();
        idle(); rd(4, 0, 2'b01); settle();
        check_eq("sim_cnt_zero", 32'(HazardD), 32'h0);
        wr(4, 32'h46); step();
        idle(); rd(4, 0, 2'b01); RdD = 4; settle();
        check_eq("no_underflow_hazard", 32'(HazardD), 32'h0);
        check_eq("no_underflow_ready", 32'(ReserveReady), 32'h1);
        check_eq("release_zero_data", rdata(0), 32'h46);
        idle(); rsv(0); step();
        idle(); rd(0, 0, 2'b11); RdD = 0; settle();
        check_eq("x0_reserve_hazard", 32'(HazardD), 32'h0);
        check_eq("x0_ready", 32'(ReserveReady), 32'h1);

        // Flush with concurrent write and reserve
        idle(); rsv(2); step(); rsv(6); step(); rsv(6); step();
        idle(); rd(2, 6, 2'b11); settle();
        check_eq("pre_flush_hazard", 32'(HazardD), 32'h3);
        Flush = 1'b1; wr(6, 32'h55); rsv(2); step();
        idle(); rd(2, 6, 2'b11); settle();
        check_eq("flush_hazard", 32'(HazardD), 32'h0);
        check_eq("flush_stall", 32'(StallD), 32'h0);
        check_eq("flush_write_kept", rdata(1), 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
